bin2bcd_conv: RTL and testbench
===============================

# bin2bcd_conv

Iterative binary-to-BCD converter that feeds the four-digit seven-segment display stage. It accepts a 16-bit unsigned binary value on a start strobe and converts it with the shift-add-3 (double-dabble) method, one bit per clock. It presents a stable 16-bit packed BCD word, four nibbles with digit 3 in [15:12], which connects directly to the display's 16-bit data input. Values above the display range saturate to 9999 and raise an overflow flag.

## Interface

Parameters:
- LIMIT, 9999: saturation threshold. Legal range 0..9999.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low; one clock, synchronous active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  16  unsigned binary operand; sampled with start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd/ovf update.
- bcd  out  16  packed BCD result {d3,d2,d1,d0}; held between conversions.
- ovf  out  1  result was saturated; held with bcd.

## Operation

- States:
  - IDLE.
  - SHIFT: 16 iterations.
  - FINISH.
- IDLE to SHIFT when start=1:
  - Latch bin into a 16-bit shift register and an operand copy.
  - Clear the 20-bit scratch accumulator (5 digits).
  - Set iteration counter = 0.
- SHIFT, each cycle:
  - Add 3 to every scratch nibble ≥5. Nibble arithmetic is 4-bit with no inter-nibble carry, since a corrected nibble is ≤12.
  - Shift {scratch, shiftreg} left by 1.
  - Increment the counter.
  - After the 16th iteration (counter = 15 at the edge), go to FINISH.
- FINISH, one cycle, then IDLE:
  - If the latched operand > LIMIT: bcd = 16'h9999, ovf = 1.
  - Else: bcd = scratch[15:0], ovf = 0.
  - done = 1 for exactly this transition.
- Scratch digit 4 (bits [19:16]) is internal only; it is nonzero only when the operand ≥10000, which saturation already covers.
- start while busy is ignored; bin changes while busy have no effect.
- bcd/ovf change only on the done edge or on reset.

## Timing

- Reset (rst_n=0 at a rising edge):
  - busy=0, done=0, bcd=16'h0000, ovf=0.
  - State IDLE, scratch/counter cleared.
  - Reset wins over start in the same cycle.
- Reset mid-conversion aborts immediately: no done pulse, outputs take reset values.
- Let E0 be the edge sampling start=1 in IDLE:
  - busy=1 after E0.
  - Iterations occur at edges E1..E16.
  - FINISH is active between E16 and E17.
  - At E17: bcd/ovf update, done=1, busy=0.
  - done falls at E18 unless a new result completes.
  - Latency from start sample to done visible: 17 cycles. busy high for 17 cycles.
- Back-to-back: start=1 in the cycle after E17 (done high, state IDLE) is accepted. Maximum throughput is one conversion per 18 cycles.
- done and busy are never high together.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with start=1 and bin=16'h1234 → busy=0, done=0, bcd=16'h0000, ovf=0; no conversion starts.
- Nominal: bin=1234 (16'h04D2), start pulse → busy high for exactly 17 cycles, done pulse 17 edges after sample, bcd=16'h1234, ovf=0; bcd holds after done falls.
- Boundaries (sequential conversions):
  - bin=0 → 16'h0000, ovf=0.
  - bin=9 → 16'h0009.
  - bin=9999 → 16'h9999, ovf=0.
- Saturation (sequential conversions):
  - bin=10000 → bcd=16'h9999, ovf=1.
  - bin=16'hFFFF → bcd=16'h9999, ovf=1.
  - Next bin=42 → bcd=16'h0042, ovf=0.
- Busy protection: start with bin=500, then start=1 with bin=777 for cycles 3..10 of the conversion → single done, bcd=16'h0500. A start in the done cycle with bin=777 → second done 18 cycles after the first, bcd=16'h0777.
- Abort: start with bin=8765, assert rst_n=0 at the 8th cycle of busy → no done pulse, bcd=16'h0000, busy=0. New start with bin=8765 after release → bcd=16'h8765 with nominal latency.

Source files
------------

// File: rtl/bin2bcd_conv.sv
// Iterative 16-bit binary to 4-digit packed BCD converter (shift-add-3, one bit per clock).
// Results above LIMIT saturate to 9999 and raise ovf; bcd/ovf hold between conversions.
module bin2bcd_conv #(
  parameter int unsigned LIMIT = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] opnd_q, opnd_d;
  logic [19:0] scratch_q, scratch_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  // A corrected nibble never exceeds 12, so per-nibble adds need no carry chain.
  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      opnd_q    <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      opnd_q    <= opnd_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == 4'd15) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    opnd_d    = opnd_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = (state_q == S_FINISH);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin;
          opnd_d    = bin;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      S_SHIFT: begin
        {scratch_d, shift_d} = {add3(scratch_q), shift_q} << 1;
        cnt_d = cnt_q + 4'd1;
      end
      S_FINISH: begin
        if (32'(opnd_q) > LIMIT) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = scratch_q[15:0];
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = done_q;
    bcd     = bcd_q;
    ovf     = ovf_q;
    state_o = state_q;
  end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed bench for bin2bcd_conv: reset, table of conversions, busy protection,
// back-to-back start and mid-conversion abort.
module tb_bin2bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  bin2bcd_conv #(.LIMIT(9999)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ovf     (ovf),
    .state_o (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b expected not both", busy, done);
      end
    end
  end

  // Waits for done after the start-sampling edge; returns edges counted (0 = timeout).
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic do_conv(input string name, input logic [15:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int edges;
    logic [15:0] prev;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = $urandom_range(0, 16'hFFFF);
    chk({name, "_busy_after_start"}, busy, 1'b1);
    wait_done(edges);
    chk({name, "_latency"}, edges, 17);
    chk({name, "_bcd"}, bcd, exp_bcd);
    chk({name, "_ovf"}, ovf, exp_ovf);
    chk({name, "_busy_at_done"}, busy, 1'b0);
    prev = bcd;
    @(posedge clk); #1;
    chk({name, "_done_fall"}, done, 1'b0);
    chk({name, "_bcd_hold"}, bcd, prev);
  endtask

  vec_t vecs[9];

  initial begin
    int edges;
    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd0,     16'h0000, 1'b0};
    vecs[2] = '{16'd9,     16'h0009, 1'b0};
    vecs[3] = '{16'd9999,  16'h9999, 1'b0};
    vecs[4] = '{16'd10000, 16'h9999, 1'b1};
    vecs[5] = '{16'hFFFF,  16'h9999, 1'b1};
    vecs[6] = '{16'd42,    16'h0042, 1'b0};
    vecs[7] = '{16'd100,   16'h0100, 1'b0};
    vecs[8] = '{16'd5059,  16'h5059, 1'b0};

    // Reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    bin   = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_bcd",  bcd,  16'h0000);
      chk("rst_ovf",  ovf,  1'b0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 1'b0);
    chk("post_rst_state", state_o, 2'd0);

    // Table-driven conversions
    for (int i = 0; i < 9; i++) begin
      do_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Busy protection: starts during cycles 3..10 are ignored
    start = 1'b1;
    bin   = 16'd500;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      start = (i >= 2 && i <= 9);
      bin   = (i >= 2 && i <= 9) ? 16'd777 : 16'd0;
      @(posedge clk); #1;
      if (done) begin
        edges = i;
        break;
      end
    end
    start = 1'b0;
    chk("prot_latency", edges, 17);
    chk("prot_bcd", bcd, 16'h0500);
    chk("prot_ovf", ovf, 1'b0);
    // Start in the done cycle is accepted
    start = 1'b1;
    bin   = 16'd777;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        edges = i;
        break;
      end
    end
    chk("b2b_spacing", edges, 18);
    chk("b2b_bcd", bcd, 16'h0777);

    // Abort with reset in the 8th busy cycle
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 16'd8765;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_bcd", bcd, 16'h0000);
    chk("abort_done", done, 1'b0);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (done) edges = i;
    end
    chk("abort_no_done", edges, 0);
    chk("abort_bcd_held", bcd, 16'h0000);
    do_conv("after_abort", 16'd8765, 16'h8765, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
